mips_fetch_queue: RTL
=====================

// Module: mips_fetch_queue
// PURPOSE
//  Instruction-fetch stage placed directly upstream of the single-cycle MIPS core.
//  Owns the fetch PC and issues word reads to a 1-cycle-latency instruction memory.
//  Buffers returned words, each with its PC, in a small FIFO.
//  Presents them to the core over a valid/ready handshake.
//  The core redirects fetch on taken branches (beq/bne) with a flush.
// PARAMETERS
//  DEPTH     4      FIFO entries (power of 2, >=2)
//  RESET_PC  32'd0  byte address of first fetch after reset
// PORTS
//  clk             in   1   single clock, all state on posedge
//  rst             in   1   synchronous reset, active-high
//  imem_req        out  1   read request this cycle
//  imem_addr       out  32  word address (fetch_pc>>2), valid when imem_req=1
//  imem_rdata      in   32  instruction word, valid the cycle after imem_req
//  inst_valid      out  1   FIFO head holds an instruction
//  inst            out  32  head instruction word
//  inst_pc         out  32  byte PC of head instruction
//  inst_ready      in   1   core accepts head this cycle
//  redirect_valid  in   1   taken branch: flush and refetch
//  redirect_pc     in   32  new byte PC; bits [1:0] ignored (forced 0)
//  fifo_level      out  $clog2(DEPTH)+1  occupied entries (debug)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Reset (rst=1 at posedge):
//    - fetch_pc=RESET_PC; FIFO empty; in-flight flag cleared.
//    - imem_req=0, inst_valid=0, inst=0, inst_pc=0, fifo_level=0.
//    - While rst is high, imem_req=0 combinationally.
//  - Issue rule: imem_req = !rst && !redirect_valid && (level + inflight < DEPTH).
//    - inflight is 0 or 1.
//    - On issue, fetch_pc <= fetch_pc+4, modulo 2^32; 0xFFFFFFFC wraps to 0.
//  - Response:
//    - Cycle after an issue, {imem_rdata, issued_pc} is pushed at that cycle's posedge.
//    - It is visible as head (inst_valid=1) from the next cycle.
//    - Latency is req -> inst_valid: 2 cycles.
//  - Pop: on a posedge with inst_valid && inst_ready, the head is removed.
//    - inst and inst_pc update to the next entry; no bubble if the FIFO holds more.
//  - Simultaneous push and pop: level unchanged, ordering preserved.
//    - Full plus pop: the credit frees the issue slot the same cycle, because issue
//      uses level after pop.
//  - Steady state, inst_ready held 1: one instruction per cycle after fill.
//  - Full (level+inflight==DEPTH): imem_req=0; fetch_pc holds.
//  - inst_ready with inst_valid=0: ignored.
//  - Redirect (redirect_valid=1 at posedge):
//    - FIFO cleared; level=0.
//    - In-flight response is dropped: not pushed in the following cycle.
//    - fetch_pc <= {redirect_pc[31:2],2'b00}.
//    - No issue in the redirect cycle; first new issue is the next cycle.
//    - Any handshake in the same cycle still completes. The consumed word is lost
//      with the flush, and redirect takes priority over push.
//  - Redirect on consecutive cycles: the last one wins; each flushes.
//  - Reset mid-operation has priority over redirect, push and pop.
//  - Empty FIFO: inst/inst_pc hold their last value (0 after reset); unchecked.
// TESTING
//  - Reset then inst_ready=1, imem = word i at addr i:
//    - imem_req at cycle 1 with addr 0.
//    - inst_valid at cycle 3 with inst_pc=0.
//    - Thereafter inst_pc=4,8,12... one per cycle.
//  - inst_ready=0 after reset:
//    - Exactly DEPTH(4) requests issued, addr 0..3; then imem_req=0; fifo_level=4.
//    - Raise ready: pcs 0,4,8,12,16 emerge back-to-back with no gap.
//  - Redirect to 0x40 with 3 entries queued and 1 in flight:
//    - Next cycle fifo_level=0 and imem_addr=0x10.
//    - First inst_valid shows inst_pc=0x40; the stale word is never presented.
//  - redirect_pc=0x43: fetch resumes at 0x40.
//  - RESET_PC=32'hFFFFFFF8: pcs FFFFFFF8, FFFFFFFC, 0, 4 in order.
//  - rst asserted while full with ready=1 and redirect_valid=1:
//    - Next cycle all outputs 0 and fifo_level=0.
//    - First fetch is RESET_PC.

Source files
------------

// File: rtl/mips_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues 1-cycle-latency word reads and
// buffers returned words with their PCs in a FIFO presented over valid/ready.
module mips_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       imem_req,
   output logic [31:0]                imem_addr,
   input  logic [31:0]                imem_rdata,
   output logic                       inst_valid,
   output logic [31:0]                inst,
   output logic [31:0]                inst_pc,
   input  logic                       inst_ready,
   input  logic                       redirect_valid,
   input  logic [31:0]                redirect_pc,
   output logic [$clog2(DEPTH):0]     fifo_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [31:0]   mem_inst_q [DEPTH];
   logic [31:0]   mem_pc_q   [DEPTH];

   logic          pop, push;
   logic [LW-1:0] level_after_pop;
   logic [LW:0]   credits_used;

   assign inst_valid = (level_q != '0);
   assign inst       = mem_inst_q[rd_ptr_q];
   assign inst_pc    = mem_pc_q[rd_ptr_q];
   assign fifo_level = level_q;
   assign imem_addr  = {2'b00, fetch_pc_q[31:2]};

   always_comb begin
      pop             = inst_valid && inst_ready;
      // A redirect in the response cycle drops the in-flight word.
      push            = inflight_q && !redirect_valid;
      level_after_pop = level_q - LW'(pop);
      // Issue credit counts the slot freed by a same-cycle pop.
      credits_used    = {1'b0, level_after_pop} + (LW + 1)'(inflight_q);
      imem_req        = !rst && !redirect_valid && (credits_used < (LW + 1)'(DEPTH));
   end

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      rd_ptr_d      = rd_ptr_q + AW'(pop);
      wr_ptr_d      = wr_ptr_q;
      level_d       = level_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         wr_ptr_d   = rd_ptr_d;
         level_d    = '0;
      end else begin
         inflight_d = imem_req;
         if (imem_req) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
         end
         wr_ptr_d = wr_ptr_q + AW'(push);
         level_d  = level_q + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         level_q       <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_inst_q[i] <= '0;
            mem_pc_q[i]   <= '0;
         end
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         level_q       <= level_d;
         if (push) begin
            mem_inst_q[wr_ptr_q] <= imem_rdata;
            mem_pc_q[wr_ptr_q]   <= inflight_pc_q;
         end
      end
   end

endmodule
